// File: rtl/match_result_collector_pkg.sv
// Shared constants and state encoding for the match result collector.
// Widths follow the match_pu result interface: slot index is log2(PU_NUM),
// match length covers 0..2^MAX_MATCH_LEN_LOG2 inclusive.
package match_result_collector_pkg;

  localparam int PU_NUM             = 4;
  localparam int ADDR_W             = 16;
  localparam int MAX_MATCH_LEN_LOG2 = 8;
  localparam int LEN_W              = MAX_MATCH_LEN_LOG2 + 1;
  localparam int SLOT_W             = $clog2(PU_NUM);
  localparam int MIN_MATCH          = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/match_best_select.sv
// Purpose: combinational winner pick between the running best {len, slot}
//          and a candidate {len, slot}; longer wins, ties go to the lower slot.
// Ports:   best_len/best_slot (current), cand_len/cand_slot (candidate),
//          cand_wins, win_len/win_slot (selected pair). Latency 0, no flow control.
module match_best_select
  import match_result_collector_pkg::*;
(
  input  logic [LEN_W-1:0]  best_len,
  input  logic [SLOT_W-1:0] best_slot,
  input  logic [LEN_W-1:0]  cand_len,
  input  logic [SLOT_W-1:0] cand_slot,
  output logic              cand_wins,
  output logic [LEN_W-1:0]  win_len,
  output logic [SLOT_W-1:0] win_slot
);

  // Strict compares: an equal pair never displaces the current best.
  assign cand_wins = (cand_len > best_len) ||
                     ((cand_len == best_len) && (cand_slot < best_slot));
  assign win_len   = cand_wins ? cand_len  : best_len;
  assign win_slot  = cand_wins ? cand_slot : best_slot;

endmodule

// File: rtl/match_result_collector.sv
// Purpose: collect per-slot match_pu results for one head address and emit a
//          single best-match record. Latency: record valid 1 cycle after the
//          final result (1 cycle after accept for an empty mask). Backpressure:
//          results are never stalled; a finished job parks in HOLD (job_ready=0)
//          while the output register is occupied.
// Ports:   job_* (valid/ready job intake), res_* (strobe-only result stream),
//          out_* (valid/ready best-match record), err_sticky (dropped result seen).
module match_result_collector
  import match_result_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  input  logic [ADDR_W-1:0] job_head_addr,
  input  logic [PU_NUM-1:0] job_slot_mask,
  output logic              job_ready,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [SLOT_W-1:0] res_slot_idx,
  input  logic [LEN_W-1:0]  res_match_len,
  input  logic              res_extp,
  input  logic              res_is_burst,
  input  logic              res_read_unsafe,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_head_addr,
  output logic [SLOT_W-1:0] out_slot_idx,
  output logic [LEN_W-1:0]  out_match_len,
  output logic              out_hit,
  output logic              out_extend_req,
  output logic              out_all_unsafe,
  output logic              err_sticky
);

  state_t            state;
  state_t            next_state;

  logic [ADDR_W-1:0] head_addr;
  logic [PU_NUM-1:0] pending;
  logic [LEN_W-1:0]  best_len;
  logic [SLOT_W-1:0] best_slot;
  logic              best_ext;
  logic              all_unsafe;

  logic              job_take;
  logic              load_out;
  logic              out_free;
  logic              res_take;
  logic [PU_NUM-1:0] slot_oh;
  logic [PU_NUM-1:0] pending_nxt;

  logic              cand_wins;
  logic [LEN_W-1:0]  win_len;
  logic [SLOT_W-1:0] win_slot;
  logic [LEN_W-1:0]  fold_len;
  logic [SLOT_W-1:0] fold_slot;
  logic              fold_ext;
  logic              fold_unsafe;
  logic              fold_hit;

  // A result is only usable while collecting, for this head, on a slot still owed.
  assign res_take    = res_valid && (state == ST_COLLECT) &&
                       (res_addr == head_addr) && pending[res_slot_idx];
  assign slot_oh     = {{(PU_NUM-1){1'b0}}, 1'b1} << res_slot_idx;
  assign pending_nxt = res_take ? (pending & ~slot_oh) : pending;
  assign out_free    = !out_valid || out_ready;

  match_best_select u_best (
    .best_len  (best_len),
    .best_slot (best_slot),
    .cand_len  (res_match_len),
    .cand_slot (res_slot_idx),
    .cand_wins (cand_wins),
    .win_len   (win_len),
    .win_slot  (win_slot)
  );

  // Best-so-far including the result on the wire this cycle, so the final
  // result can go straight into the output register.
  assign fold_len    = res_take ? win_len  : best_len;
  assign fold_slot   = res_take ? win_slot : best_slot;
  assign fold_ext    = (res_take && cand_wins) ? (res_extp && !res_is_burst) : best_ext;
  assign fold_unsafe = res_take ? (all_unsafe && res_read_unsafe) : all_unsafe;
  assign fold_hit    = (fold_len >= LEN_W'(MIN_MATCH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    job_ready  = 1'b0;
    job_take   = 1'b0;
    load_out   = 1'b0;
    case (state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          job_take   = 1'b1;
          next_state = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (pending_nxt == '0) begin
          if (out_free) begin
            load_out   = 1'b1;
            next_state = ST_IDLE;
          end else begin
            next_state = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_free) begin
          load_out   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_addr      <= '0;
      pending        <= '0;
      best_len       <= '0;
      best_slot      <= '0;
      best_ext       <= 1'b0;
      all_unsafe     <= 1'b1;
      out_valid      <= 1'b0;
      out_head_addr  <= '0;
      out_slot_idx   <= '0;
      out_match_len  <= '0;
      out_hit        <= 1'b0;
      out_extend_req <= 1'b0;
      out_all_unsafe <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      if (res_valid && !res_take) begin
        err_sticky <= 1'b1;
      end

      if (job_take) begin
        head_addr  <= job_head_addr;
        pending    <= job_slot_mask;
        best_len   <= '0;
        best_slot  <= '0;
        best_ext   <= 1'b0;
        all_unsafe <= 1'b1;
      end else if (state == ST_COLLECT) begin
        pending    <= pending_nxt;
        best_len   <= fold_len;
        best_slot  <= fold_slot;
        best_ext   <= fold_ext;
        all_unsafe <= fold_unsafe;
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // In HOLD res_take is 0, so the fold_* values equal the stored best.
      if (load_out) begin
        out_valid      <= 1'b1;
        out_head_addr  <= head_addr;
        out_slot_idx   <= fold_slot;
        out_match_len  <= fold_len;
        out_hit        <= fold_hit;
        out_extend_req <= fold_ext && fold_hit;
        out_all_unsafe <= fold_unsafe;
      end
    end
  end

endmodule

// File: tb/tb_match_result_collector.sv
module tb_match_result_collector;
  import match_result_collector_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              job_valid;
  logic [ADDR_W-1:0] job_head_addr;
  logic [PU_NUM-1:0] job_slot_mask;
  logic              job_ready;
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [SLOT_W-1:0] res_slot_idx;
  logic [LEN_W-1:0]  res_match_len;
  logic              res_extp;
  logic              res_is_burst;
  logic              res_read_unsafe;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_head_addr;
  logic [SLOT_W-1:0] out_slot_idx;
  logic [LEN_W-1:0]  out_match_len;
  logic              out_hit;
  logic              out_extend_req;
  logic              out_all_unsafe;
  logic              err_sticky;

  int n_pass   = 0;
  int n_checks = 0;

  match_result_collector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .job_valid       (job_valid),
    .job_head_addr   (job_head_addr),
    .job_slot_mask   (job_slot_mask),
    .job_ready       (job_ready),
    .res_valid       (res_valid),
    .res_addr        (res_addr),
    .res_slot_idx    (res_slot_idx),
    .res_match_len   (res_match_len),
    .res_extp        (res_extp),
    .res_is_burst    (res_is_burst),
    .res_read_unsafe (res_read_unsafe),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_head_addr   (out_head_addr),
    .out_slot_idx    (out_slot_idx),
    .out_match_len   (out_match_len),
    .out_hit         (out_hit),
    .out_extend_req  (out_extend_req),
    .out_all_unsafe  (out_all_unsafe),
    .err_sticky      (err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_job(input logic [ADDR_W-1:0] head, input logic [PU_NUM-1:0] mask);
    job_valid     = 1'b1;
    job_head_addr = head;
    job_slot_mask = mask;
    tick();
    job_valid     = 1'b0;
  endtask

  task automatic send_res(input logic [ADDR_W-1:0] addr, input logic [SLOT_W-1:0] slot,
                          input logic [LEN_W-1:0] len, input logic extp,
                          input logic burst, input logic unsafe);
    res_valid       = 1'b1;
    res_addr        = addr;
    res_slot_idx    = slot;
    res_match_len   = len;
    res_extp        = extp;
    res_is_burst    = burst;
    res_read_unsafe = unsafe;
    tick();
    res_valid       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; job_valid = 1'b0; job_head_addr = '0; job_slot_mask = '0;
    res_valid = 1'b0; res_addr = '0; res_slot_idx = '0; res_match_len = '0;
    res_extp = 1'b0; res_is_burst = 1'b0; res_read_unsafe = 1'b0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_len", 32'(out_match_len), 32'd0);
    chk("rst_out_unsafe", 32'(out_all_unsafe), 32'd0);
    chk("rst_err", 32'(err_sticky), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_job_ready", 32'(job_ready), 32'd1);

    // Four-slot job, longest wins, tie goes to lower slot
    out_ready = 1'b1;
    send_job(16'h0100, 4'b1111);
    chk("t1_job_ready_collect", 32'(job_ready), 32'd0);
    send_res(16'h0100, 2'd3, 9'd5, 1'b0, 1'b0, 1'b0);
    send_res(16'h0100, 2'd1, 9'd9, 1'b0, 1'b0, 1'b0);
    send_res(16'h0100, 2'd2, 9'd9, 1'b0, 1'b0, 1'b0);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    send_res(16'h0100, 2'd0, 9'd2, 1'b0, 1'b0, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_slot", 32'(out_slot_idx), 32'd1);
    chk("t1_len", 32'(out_match_len), 32'd9);
    chk("t1_hit", 32'(out_hit), 32'd1);
    chk("t1_head", 32'(out_head_addr), 32'h100);
    chk("t1_all_unsafe", 32'(out_all_unsafe), 32'd0);
    chk("t1_job_ready_idle", 32'(job_ready), 32'd1);
    tick();
    chk("t1_consumed", 32'(out_valid), 32'd0);

    // Single-compare full match requests extension
    send_job(16'h0200, 4'b0101);
    send_res(16'h0200, 2'd0, 9'd16, 1'b1, 1'b0, 1'b0);
    send_res(16'h0200, 2'd2, 9'd4, 1'b0, 1'b0, 1'b0);
    chk("t2_slot", 32'(out_slot_idx), 32'd0);
    chk("t2_len", 32'(out_match_len), 32'd16);
    chk("t2_extend", 32'(out_extend_req), 32'd1);
    tick();

    // Burst result never requests extension
    send_job(16'h0200, 4'b0101);
    send_res(16'h0200, 2'd0, 9'd40, 1'b1, 1'b1, 1'b0);
    send_res(16'h0200, 2'd2, 9'd4, 1'b0, 1'b0, 1'b0);
    chk("t2b_len", 32'(out_match_len), 32'd40);
    chk("t2b_extend", 32'(out_extend_req), 32'd0);
    tick();

    // All unsafe, no hit
    send_job(16'h0300, 4'b0011);
    send_res(16'h0300, 2'd0, 9'd0, 1'b0, 1'b0, 1'b1);
    send_res(16'h0300, 2'd1, 9'd0, 1'b0, 1'b0, 1'b1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_len", 32'(out_match_len), 32'd0);
    chk("t3_hit", 32'(out_hit), 32'd0);
    chk("t3_all_unsafe", 32'(out_all_unsafe), 32'd1);
    tick();
    send_job(16'h0300, 4'b0011);
    send_res(16'h0300, 2'd0, 9'd2, 1'b0, 1'b0, 1'b0);
    send_res(16'h0300, 2'd1, 9'd0, 1'b0, 1'b0, 1'b1);
    chk("t3b_len", 32'(out_match_len), 32'd2);
    chk("t3b_hit", 32'(out_hit), 32'd0);
    chk("t3b_all_unsafe", 32'(out_all_unsafe), 32'd0);
    tick();

    // Backpressure: second job parks in HOLD, then both drain without a bubble
    out_ready = 1'b0;
    send_job(16'h0400, 4'b0001);
    send_res(16'h0400, 2'd0, 9'd7, 1'b0, 1'b0, 1'b0);
    chk("t4_a_valid", 32'(out_valid), 32'd1);
    send_job(16'h0500, 4'b0010);
    send_res(16'h0500, 2'd1, 9'd12, 1'b0, 1'b0, 1'b0);
    chk("t4_hold_job_ready", 32'(job_ready), 32'd0);
    chk("t4_hold_head", 32'(out_head_addr), 32'h400);
    tick();
    chk("t4_stable_len", 32'(out_match_len), 32'd7);
    chk("t4_stable_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t4_b_valid", 32'(out_valid), 32'd1);
    chk("t4_b_head", 32'(out_head_addr), 32'h500);
    chk("t4_b_len", 32'(out_match_len), 32'd12);
    chk("t4_b_slot", 32'(out_slot_idx), 32'd1);
    chk("t4_idle_job_ready", 32'(job_ready), 32'd1);
    tick();
    chk("t4_drained", 32'(out_valid), 32'd0);
    chk("t4_no_err", 32'(err_sticky), 32'd0);

    // Protocol errors are dropped; job completes from the good results only
    send_job(16'h0600, 4'b0011);
    send_res(16'h0601, 2'd0, 9'd30, 1'b0, 1'b0, 1'b0);
    chk("t5_addr_err", 32'(err_sticky), 32'd1);
    send_res(16'h0600, 2'd0, 9'd6, 1'b0, 1'b0, 1'b0);
    send_res(16'h0600, 2'd0, 9'd20, 1'b0, 1'b0, 1'b0);
    chk("t5_dup_no_complete", 32'(out_valid), 32'd0);
    send_res(16'h0600, 2'd1, 9'd3, 1'b0, 1'b0, 1'b0);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_len", 32'(out_match_len), 32'd6);
    chk("t5_slot", 32'(out_slot_idx), 32'd0);
    tick();

    // Reset mid-collect drops the job and an unconsumed record
    out_ready = 1'b0;
    send_job(16'h06F0, 4'b0001);
    send_res(16'h06F0, 2'd0, 9'd8, 1'b0, 1'b0, 1'b0);
    send_job(16'h0700, 4'b1111);
    send_res(16'h0700, 2'd2, 9'd5, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_err_cleared", 32'(err_sticky), 32'd0);
    tick();
    chk("t6_job_ready", 32'(job_ready), 32'd1);
    send_res(16'h0700, 2'd3, 9'd5, 1'b0, 1'b0, 1'b0);
    chk("t6_idle_res_err", 32'(err_sticky), 32'd1);

    // Empty mask completes one cycle after accept
    out_ready = 1'b1;
    send_job(16'h0800, 4'b0000);
    chk("t7_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("t7_valid", 32'(out_valid), 32'd1);
    chk("t7_head", 32'(out_head_addr), 32'h800);
    chk("t7_len", 32'(out_match_len), 32'd0);
    chk("t7_slot", 32'(out_slot_idx), 32'd0);
    chk("t7_hit", 32'(out_hit), 32'd0);
    chk("t7_all_unsafe", 32'(out_all_unsafe), 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
